// File: rtl/coin_score.sv
// coin_score: turns coin pickups into scoring events. Each newly taken coin
// produces one ADD cycle that bumps the BCD score and coin count, fires a
// pickup strobe and restarts the "+points" popup at that coin's tile.
module coin_score #(
    parameter int NUM_COINS    = 10,
    parameter int COIN_TENS    = 1,
    parameter int POPUP_FRAMES = 32
) (
    input  logic                       frame_clk,
    input  logic                       RESET,
    input  logic                       clear,
    input  logic [NUM_COINS-1:0]       taken,
    input  logic [NUM_COINS-1:0][9:0]  coin_row,
    input  logic [NUM_COINS-1:0][9:0]  coin_col,
    output logic [15:0]                score_bcd,
    output logic [3:0]                 coin_count,
    output logic                       all_collected,
    output logic                       pickup_pulse,
    output logic                       popup_active,
    output logic [9:0]                 popup_row,
    output logic [9:0]                 popup_col,
    output logic [5:0]                 popup_age
);

    typedef enum logic [1:0] {IDLE, ADD, SHOW} state_t;

    state_t               state, state_nxt;
    logic [NUM_COINS-1:0] s1, s2, seen, pending;
    logic [3:0]           sel;
    logic                 commit;
    logic [15:0]          score_add;
    logic [3:0]           count_add;
    logic                 age_last;

    assign pending  = s2 & ~seen;
    assign commit   = (state == ADD) && (pending != '0);
    assign age_last = (popup_age == 6'(POPUP_FRAMES - 1));

    // Lowest-index pending coin wins; scanning downward leaves the lowest last.
    // NOTE: every always_comb output gets a default first so no path holds an old value (no latch).
    always_comb begin
        sel = '0;
        for (int i = NUM_COINS - 1; i >= 0; i--) begin
            if (pending[i]) sel = 4'(i);
        end
    end

    // Score plus COIN_TENS*10 with BCD carry ripple; saturates at 9990.
    always_comb begin
        logic [4:0] t_raw, h_raw, k_raw;
        logic [3:0] t_new, h_new, k_new;
        logic       c1, c2, c3;
        t_raw = {1'b0, score_bcd[7:4]} + 5'(COIN_TENS);
        c1    = (t_raw > 5'd9);
        t_new = c1 ? 4'(t_raw - 5'd10) : t_raw[3:0];
        h_raw = {1'b0, score_bcd[11:8]} + {4'b0, c1};
        c2    = (h_raw > 5'd9);
        h_new = c2 ? 4'(h_raw - 5'd10) : h_raw[3:0];
        k_raw = {1'b0, score_bcd[15:12]} + {4'b0, c2};
        c3    = (k_raw > 5'd9);
        k_new = c3 ? 4'(k_raw - 5'd10) : k_raw[3:0];
        score_add = c3 ? 16'h9990 : {k_new, h_new, t_new, 4'h0};
        count_add = (coin_count < 4'(NUM_COINS)) ? coin_count + 4'd1 : coin_count;
    end

    // Next-state logic: serialise pickups, SHOW is preempted by any new pickup.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (pending != '0) state_nxt = ADD;
            ADD: begin
                // A coin that dropped before its ADD simply falls back.
                if (commit || popup_active) state_nxt = SHOW;
                else                        state_nxt = IDLE;
            end
            SHOW: begin
                if (pending != '0) state_nxt = ADD;
                else if (age_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Two-flop synchroniser for taken, plus the already-counted mask.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge frame_clk or negedge RESET) begin
        if (!RESET) begin
            s1   <= '0;
            s2   <= '0;
            seen <= '0;
        end else if (clear) begin
            s1   <= '0;
            s2   <= '0;
            seen <= '0;
        end else begin
            s1   <= taken;
            s2   <= s1;
            seen <= (seen & s2) | (commit ? (NUM_COINS'(1) << sel) : '0);
        end
    end

    // FSM state register.
    always_ff @(posedge frame_clk or negedge RESET) begin
        if (!RESET)     state <= IDLE;
        else if (clear) state <= IDLE;
        else            state <= state_nxt;
    end

    // Score, count and popup registers; all commit together at the ADD edge.
    always_ff @(posedge frame_clk or negedge RESET) begin
        if (!RESET) begin
            score_bcd     <= '0;
            coin_count    <= '0;
            all_collected <= 1'b0;
            pickup_pulse  <= 1'b0;
            popup_active  <= 1'b0;
            popup_row     <= '0;
            popup_col     <= '0;
            popup_age     <= '0;
        end else if (clear) begin
            score_bcd     <= '0;
            coin_count    <= '0;
            all_collected <= 1'b0;
            pickup_pulse  <= 1'b0;
            popup_active  <= 1'b0;
            popup_row     <= '0;
            popup_col     <= '0;
            popup_age     <= '0;
        end else begin
            pickup_pulse <= commit;
            if (commit) begin
                score_bcd     <= score_add;
                coin_count    <= count_add;
                all_collected <= (count_add == 4'(NUM_COINS));
                popup_row     <= coin_row[sel];
                popup_col     <= coin_col[sel];
                popup_age     <= '0;
                popup_active  <= 1'b1;
            end else if (state == SHOW && pending == '0) begin
                if (age_last) popup_active <= 1'b0;
                else          popup_age    <= popup_age + 6'd1;
            end
        end
    end

endmodule

// File: tb/tb_coin_score.sv
// Self-checking bench for coin_score: directed latency/boundary steps, then
// random drop/raise rounds compared against an arithmetic score/count model.
module tb_coin_score;

    localparam int N = 10;

    logic             frame_clk = 1'b0;
    logic             RESET     = 1'b0;
    logic             clear     = 1'b0;
    logic [N-1:0]     taken     = '0;
    logic [N-1:0]     taken2    = '0;
    logic [N-1:0][9:0] rows, cols;

    logic [15:0] score_bcd, score2;
    logic [3:0]  coin_count, count2;
    logic        all_collected, all2, pickup_pulse, pulse2, popup_active, active2;
    logic [9:0]  popup_row, popup_col, row2, col2;
    logic [5:0]  popup_age, age2;

    int n_checks = 0;
    int n_fail   = 0;
    int pulse_cnt = 0;

    always #5 frame_clk = ~frame_clk;

    coin_score #(.NUM_COINS(N), .COIN_TENS(1), .POPUP_FRAMES(32)) dut (
        .frame_clk(frame_clk), .RESET(RESET), .clear(clear), .taken(taken),
        .coin_row(rows), .coin_col(cols),
        .score_bcd(score_bcd), .coin_count(coin_count), .all_collected(all_collected),
        .pickup_pulse(pickup_pulse), .popup_active(popup_active),
        .popup_row(popup_row), .popup_col(popup_col), .popup_age(popup_age)
    );

    coin_score #(.NUM_COINS(N), .COIN_TENS(9), .POPUP_FRAMES(32)) dut9 (
        .frame_clk(frame_clk), .RESET(RESET), .clear(clear), .taken(taken2),
        .coin_row(rows), .coin_col(cols),
        .score_bcd(score2), .coin_count(count2), .all_collected(all2),
        .pickup_pulse(pulse2), .popup_active(active2),
        .popup_row(row2), .popup_col(col2), .popup_age(age2)
    );

    // Count strobes away from the active edge.
    always @(negedge frame_clk) if (pickup_pulse) pulse_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge frame_clk);
        #1;
    endtask

    task automatic do_reset();
        taken  = '0;
        taken2 = '0;
        RESET  = 1'b0;
        tick(2);
        RESET  = 1'b1;
        tick(1);
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        to_bcd = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    initial begin
        int pts, cnt, m_count, m_score, m_pulses, pulse_base, k, last;
        logic [N-1:0] drop, raise;

        for (int i = 0; i < N; i++) begin
            rows[i] = 10'($urandom_range(0, 1023));
            cols[i] = 10'($urandom_range(0, 1023));
        end

        // Reset state
        do_reset();
        check("rst_score", score_bcd, 16'h0000);
        check("rst_count", coin_count, 0);
        check("rst_all", all_collected, 0);
        check("rst_pulse", pickup_pulse, 0);
        check("rst_active", popup_active, 0);
        check("rst_age", popup_age, 0);

        // 1: single pickup latency and popup lifetime
        taken[3] = 1'b1;
        tick(3);
        check("t1_pre_count", coin_count, 0);
        check("t1_pre_pulse", pickup_pulse, 0);
        tick(1);
        check("t1_score", score_bcd, 16'h0010);
        check("t1_count", coin_count, 1);
        check("t1_pulse", pickup_pulse, 1);
        check("t1_row", popup_row, rows[3]);
        check("t1_col", popup_col, cols[3]);
        check("t1_active", popup_active, 1);
        check("t1_age0", popup_age, 0);
        tick(1);
        check("t1_pulse_off", pickup_pulse, 0);
        tick(30);
        check("t1_age31", popup_age, 31);
        check("t1_still_active", popup_active, 1);
        tick(1);
        check("t1_popup_off", popup_active, 0);

        // 2: simultaneous pickups, lowest index first
        do_reset();
        taken[7] = 1'b1;
        taken[2] = 1'b1;
        tick(4);
        check("t2_pulse_a", pickup_pulse, 1);
        check("t2_row_a", popup_row, rows[2]);
        check("t2_count_a", coin_count, 1);
        tick(1);
        check("t2_gap", pickup_pulse, 0);
        tick(1);
        check("t2_pulse_b", pickup_pulse, 1);
        check("t2_row_b", popup_row, rows[7]);
        check("t2_col_b", popup_col, cols[7]);
        check("t2_score", score_bcd, 16'h0020);
        check("t2_count", coin_count, 2);

        // 3: all coins, cap and re-pick
        do_reset();
        taken = '1;
        tick(4 + 2 * 8);
        check("t3_count9", coin_count, 9);
        check("t3_all_lo", all_collected, 0);
        tick(2);
        check("t3_count10", coin_count, 10);
        check("t3_all_hi", all_collected, 1);
        check("t3_score", score_bcd, 16'h0100);
        taken[0] = 1'b0;
        tick(4);
        taken[0] = 1'b1;
        tick(5);
        check("t3_recount", coin_count, 10);
        check("t3_rescore", score_bcd, 16'h0110);
        check("t3_all_keep", all_collected, 1);

        // 4: COIN_TENS=9 saturation through repeated re-picks
        do_reset();
        pts = 0;
        for (int i = 1; i <= 112; i++) begin
            taken2[0] = 1'b1;
            tick(5);
            pts = (pts + 90 > 9990) ? 9990 : pts + 90;
            cnt = (i > N) ? N : i;
            check($sformatf("t4_score_%0d", i), score2, to_bcd(pts));
            check($sformatf("t4_count_%0d", i), count2, cnt);
            taken2[0] = 1'b0;
            tick(3);
        end
        check("t4_sat", score2, 16'h9990);

        // 5: asynchronous reset mid-SHOW, re-count after release
        do_reset();
        taken[5] = 1'b1;
        tick(4);
        tick(10);
        check("t5_age10", popup_age, 10);
        RESET = 1'b0;
        #1;
        check("t5_score0", score_bcd, 0);
        check("t5_count0", coin_count, 0);
        check("t5_active0", popup_active, 0);
        check("t5_age0", popup_age, 0);
        check("t5_row0", popup_row, 0);
        tick(1);
        RESET = 1'b1;
        tick(3);
        check("t5_not_yet", coin_count, 0);
        tick(1);
        check("t5_recount", coin_count, 1);
        check("t5_rescore", score_bcd, 16'h0010);
        check("t5_row", popup_row, rows[5]);

        // 6: new pickup preempts SHOW at age 20
        do_reset();
        taken[1] = 1'b1;
        tick(4);
        tick(20);
        check("t6_age20", popup_age, 20);
        taken[8] = 1'b1;
        tick(3);
        check("t6_age22", popup_age, 22);
        check("t6_count1", coin_count, 1);
        tick(1);
        check("t6_age_restart", popup_age, 0);
        check("t6_row", popup_row, rows[8]);
        check("t6_col", popup_col, cols[8]);
        check("t6_count2", coin_count, 2);
        check("t6_pulse", pickup_pulse, 1);

        // Random rounds after a synchronous clear
        taken = '0;
        tick(1);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("clr_score", score_bcd, 0);
        check("clr_count", coin_count, 0);
        check("clr_active", popup_active, 0);
        tick(1);
        m_count = 0;
        m_score = 0;
        m_pulses = 0;
        pulse_base = pulse_cnt;
        for (int r = 0; r < 25; r++) begin
            drop = N'($urandom) & taken;
            taken = taken & ~drop;
            tick(4);
            raise = N'($urandom) & ~taken;
            k = $countones(raise);
            last = -1;
            for (int i = 0; i < N; i++) if (raise[i]) last = i;
            taken = taken | raise;
            tick(2 * k + 6);
            m_count  = (m_count + k > N) ? N : m_count + k;
            m_score  = (m_score + 10 * k > 9990) ? 9990 : m_score + 10 * k;
            m_pulses = m_pulses + k;
            check($sformatf("rnd%0d_score", r), score_bcd, to_bcd(m_score));
            check($sformatf("rnd%0d_count", r), coin_count, m_count);
            check($sformatf("rnd%0d_all", r), all_collected, (m_count == N));
            check($sformatf("rnd%0d_pulses", r), pulse_cnt - pulse_base, m_pulses);
            if (last >= 0) begin
                check($sformatf("rnd%0d_row", r), popup_row, rows[last]);
                check($sformatf("rnd%0d_col", r), popup_col, cols[last]);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
